ram_player: RTL and testbench

RAM_PLAYER -- requirements
Module: ram_player

---
 rtl/ram_player.sv | 146 ++++++++++++++
 tb/tb_ram_player.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram_player.sv
// 8x4 RAM playback engine: steps rd_addr 0..7, showing each word for TICK_DIV
// cycles with 7-segment decodes. Define RAM_PLAYER_LOOP_EN for continuous looping.
module ram_player #(
  parameter int unsigned TICK_DIV = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [3:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [2:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [6:0] seg_data,
  output logic [6:0] seg_addr
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    mem [8];
  logic          start_q;
  logic [PW-1:0] presc;
  logic          start_edge;
  logic          busy_nx, done_nx, addr_clr, addr_inc;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    done_nx  = 1'b0;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge && !stop) begin
          state_nx = LOAD;
          busy_nx  = 1'b1;
          addr_clr = 1'b1;
        end
      end
      LOAD: begin
        if (stop) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else begin
          state_nx = SHOW;
        end
      end
      SHOW: begin
        if (stop) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else if (presc == PRESC_LAST) begin
          if (rd_addr != 3'd7) begin
            state_nx = LOAD;
            addr_inc = 1'b1;
          end else begin
`ifdef RAM_PLAYER_LOOP_EN
            state_nx = LOAD;
            addr_clr = 1'b1;
            done_nx  = 1'b1;
`else
            state_nx = DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
`endif
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // NOTE: the store is deliberately reset word by word, which makes it flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      start_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
      presc   <= '0;
    end else begin
      start_q <= start;
      busy    <= busy_nx;
      done    <= done_nx;
      if (we) mem[waddr] <= wdata;
      if (addr_clr)      rd_addr <= '0;
      else if (addr_inc) rd_addr <= rd_addr + 3'd1;
      // Sampling mem with <= returns the pre-write word on a same-cycle collision.
      if (state == LOAD) rd_data <= mem[rd_addr];
      if (state == LOAD)      presc <= '0;
      else if (state == SHOW) presc <= presc + 1'b1;
    end
  end

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign seg_data = seg7(rd_data);
  assign seg_addr = seg7({1'b0, rd_addr});

endmodule

// File: tb/tb_ram_player.sv
// Directed bench for ram_player at TICK_DIV=4 (5 cycles per address, done 40 cycles after LOAD of address 0).
module tb_ram_player;

  logic       clk = 1'b0;
  logic       rst, start, stop, we;
  logic [2:0] waddr;
  logic [3:0] wdata;
  logic       busy, done;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic [6:0] seg_data, seg_addr;

  int n_tests = 0;
  int n_fail  = 0;

  ram_player #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .we(we),
    .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .seg_data(seg_data), .seg_addr(seg_addr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic write_word(input logic [2:0] a, input logic [3:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b exp 0", done); end
    n_tests++; if (rd_addr !== 3'd0) begin n_fail++; $display("FAIL reset rd_addr got %0d exp 0", rd_addr); end
    n_tests++; if (rd_data !== 4'd0) begin n_fail++; $display("FAIL reset rd_data got %0d exp 0", rd_data); end
    n_tests++; if (seg_data !== 7'b1000000) begin n_fail++; $display("FAIL reset seg_data got %b exp 1000000", seg_data); end
    n_tests++; if (seg_addr !== 7'b1000000) begin n_fail++; $display("FAIL reset seg_addr got %b exp 1000000", seg_addr); end
  endtask

  // Addresses 0..7 hold 7..0; full single pass.
  task automatic test_playback();
    logic [2:0] ea;
    for (int a = 0; a < 8; a++) write_word(3'(a), 4'(7 - a));
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      ea = (i >= 40) ? 3'd7 : 3'(i / 5);
      n_tests++; if (busy !== (i < 40)) begin n_fail++; $display("FAIL playback busy i=%0d got %b exp %b", i, busy, (i < 40)); end
      n_tests++; if (done !== (i == 40)) begin n_fail++; $display("FAIL playback done i=%0d got %b exp %b", i, done, (i == 40)); end
      n_tests++; if (rd_addr !== ea) begin n_fail++; $display("FAIL playback rd_addr i=%0d got %0d exp %0d", i, rd_addr, ea); end
      if (i >= 1 && (i % 5 != 0 || i >= 40)) begin
        n_tests++; if (rd_data !== 4'(7 - ea)) begin n_fail++; $display("FAIL playback rd_data i=%0d got %0d exp %0d", i, rd_data, 7 - ea); end
      end
      if (i == 1) begin
        n_tests++; if (seg_data !== 7'b1111000) begin n_fail++; $display("FAIL playback seg_data(7) got %b exp 1111000", seg_data); end
      end
      if (i == 16) begin
        n_tests++; if (seg_addr !== 7'b0110000) begin n_fail++; $display("FAIL playback seg_addr(3) got %b exp 0110000", seg_addr); end
      end
    end
  endtask

  task automatic test_stop();
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      n_tests++; if (busy !== (i < 18)) begin n_fail++; $display("FAIL stop busy i=%0d got %b exp %b", i, busy, (i < 18)); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop done i=%0d got %b exp 0", i, done); end
      if (i >= 18) begin
        n_tests++; if (rd_addr !== 3'd3) begin n_fail++; $display("FAIL stop rd_addr i=%0d got %0d exp 3", i, rd_addr); end
        n_tests++; if (rd_data !== 4'd4) begin n_fail++; $display("FAIL stop rd_data i=%0d got %0d exp 4", i, rd_data); end
      end
      if (i == 17) stop = 1'b1;
      if (i == 18) stop = 1'b0;
    end
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      if (i == 11) start = 1'b1;
      if (i == 13) start = 1'b0;
      if (done === 1'b1) n_done++;
      n_tests++; if (done !== (i == 40)) begin n_fail++; $display("FAIL ignore done i=%0d got %b exp %b", i, done, (i == 40)); end
      n_tests++; if (busy !== (i < 40)) begin n_fail++; $display("FAIL ignore busy i=%0d got %b exp %b", i, busy, (i < 40)); end
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL ignore done_count got %0d exp 1", n_done); end
  endtask

  task automatic test_write_during_show();
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      if (i >= 26 && i <= 29) begin
        n_tests++; if (rd_data !== 4'd2) begin n_fail++; $display("FAIL wshow rd_data i=%0d got %0d exp 2", i, rd_data); end
      end
      if (i == 27) begin we = 1'b1; waddr = 3'd5; wdata = 4'hA; end
      if (i == 28) we = 1'b0;
    end
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      if (i == 26 || i == 29) begin
        n_tests++; if (rd_data !== 4'hA) begin n_fail++; $display("FAIL wshow next rd_data i=%0d got %h exp a", i, rd_data); end
        n_tests++; if (seg_data !== 7'b0001000) begin n_fail++; $display("FAIL wshow next seg_data i=%0d got %b exp 0001000", i, seg_data); end
      end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
    end
    n_tests++; if (rd_addr !== 3'd4) begin n_fail++; $display("FAIL rstmid pre rd_addr got %0d exp 4", rd_addr); end
    #2 rst = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid idle busy got %b exp 0", busy); end
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      if (i % 5 == 1) begin
        n_tests++; if (rd_data !== 4'd0) begin n_fail++; $display("FAIL rstmid store rd_data i=%0d got %0d exp 0", i, rd_data); end
      end
      n_tests++; if (done !== (i == 40)) begin n_fail++; $display("FAIL rstmid done i=%0d got %b exp %b", i, done, (i == 40)); end
    end
  endtask

  task automatic test_loop();
    start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop busy i=%0d got %b exp 1", i, busy); end
      n_tests++; if (done !== (i == 40 || i == 80)) begin n_fail++; $display("FAIL loop done i=%0d got %b exp %b", i, done, (i == 40 || i == 80)); end
      if (i == 39 || i == 79) begin
        n_tests++; if (rd_addr !== 3'd7) begin n_fail++; $display("FAIL loop rd_addr i=%0d got %0d exp 7", i, rd_addr); end
      end
      if (i == 40 || i == 80) begin
        n_tests++; if (rd_addr !== 3'd0) begin n_fail++; $display("FAIL loop wrap rd_addr i=%0d got %0d exp 0", i, rd_addr); end
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop stop busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL loop stop done got %b exp 0", done); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
`ifdef RAM_PLAYER_LOOP_EN
    test_loop();
`else
    test_playback();
    test_stop();
    test_start_ignored();
    test_write_during_show();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
